imul_pipe_param: RTL and testbench
==================================

// Module: imul_pipe_param
//
// PURPOSE
// - Parametrised, pipelined, fixed-latency integer multiplier; next generation of the lab1 fixed-latency multiplier.
// - Width and stage count are configurable. The pipeline accepts one operation per cycle.
// - Sits behind a val/rdy recv port ({a,b} operand pair) and drives a val/rdy send port (product), e.g. as a processor MUL unit.
//
// PARAMETERS
// - NBITS    32  operand/result width; must be a multiple of NSTAGES.
// - NSTAGES  4   pipeline depth (1..NBITS); each stage consumes NBITS/NSTAGES bits of b.
//
// PORTS
// - clk        in   1        clock; all state changes on the rising edge.
// - reset_n    in   1        asynchronous, active-low reset.
// - recv_val   in   1        operand pair valid.
// - recv_rdy   out  1        pipeline can accept this cycle.
// - recv_msg   in   2*NBITS  {a[2N-1:N], b[N-1:0]}.
// - recv_mode  in   2        only with IMUL_PIPE_MULH_EN; see CONFIGURATION.
// - send_val   out  1        product valid.
// - send_rdy   in   1        consumer accepts.
// - send_msg   out  NBITS    product.
//
// BEHAVIOUR
// - Reset (reset_n=0, asynchronous):
//   - all stage valid bits clear; send_val=0; recv_rdy=1.
//   - datapath registers are don't-care.
// - Reset mid-operation discards all in-flight ops; nothing is emitted after reset_n rises.
// - Pipeline: NSTAGES register stages; stage k holds {val, a_shifted, b_remaining, acc}.
//   - Each stage adds NBITS/NSTAGES partial products (shift-add) into acc.
// - Latency: recv accepted in cycle T -> send_val=1 in cycle T+NSTAGES (no stall); send_msg = last-stage acc.
// - Flow control (global stall): stall = val[NSTAGES-1] & !send_rdy.
//   - recv_rdy = !stall.
//   - When stalled, every stage holds.
//   - Bubbles are not compressed.
// - Throughput: 1 op/cycle while send_rdy=1.
// - Simultaneous events:
//   - When the last stage fires and a new op is accepted in the same cycle, both take effect.
//   - send_val and recv_rdy never depend combinationally on recv_val.
// - Arithmetic: send_msg = (a*b) mod 2^NBITS; identical for signed and unsigned operands; overflow silently wraps.
// - Ordering: results leave strictly in acceptance order. A transfer occurs only when val&rdy are both high in the same cycle.
//
// CONFIGURATION
// - IMUL_PIPE_MULH_EN defined: adds port recv_mode, which travels with the op down the pipe.
//   - Product widens internally to 2*NBITS.
//   - MUL=0 returns the low half. MULH=1 returns the high half signed x signed.
//   - MULHSU=2 returns the high half signed x unsigned. MULHU=3 returns the high half unsigned x unsigned.
// - IMUL_PIPE_MULH_EN undefined: no recv_mode port; low half only; accumulators are NBITS wide.
//
// STRUCTURE
// - Package imul_pipe_pkg: enum imul_mode_t {MUL, MULH, MULHSU, MULHU}; localparam helper BITS_PER_STAGE(NBITS,NSTAGES).
// - Sub-module imul_pipe_stage #(NBITS, BPS): one shift-add stage with enable.
//   - Top-level instantiates NSTAGES copies with a generate loop and owns the val/stall logic.
// - Line tracing under `ifndef SYNTHESIS: stage valid bitmap between recv and send fields.
//
// TESTING
// - Basic, NSTAGES=4: recv 3*5 at cycle 0, send_rdy=1 -> send_msg=15 exactly at cycle 4; recv_rdy stays 1.
// - Back-to-back: 8 ops streamed (0xFFFFFFFF*2, 7*-3, 0*x, 1*0x80000000, ...).
//   - Required: 8 results in order, one per cycle.
//   - Required values include 0xFFFFFFFE, 0xFFFFFFEB and 0x80000000.
// - Back-pressure: send_rdy=0 for 5 cycles with the pipe full.
//   - recv_rdy=0 and send_msg held stable.
//   - On release, results drain in order with none lost or duplicated.
// - Reset mid-flight: 3 ops in flight, pulse reset_n low asynchronously (mid-cycle).
//   - send_val=0 immediately and no stale outputs afterwards.
//   - A new op after reset completes normally.
// - Parameter sweep: NBITS in {8,16,32} x NSTAGES in {1,2,NBITS}; 500 random ops vs golden model; latency == NSTAGES.
// - MULH_EN: -2*3 gives MUL=0xFFFFFFFA, MULH=0xFFFFFFFF, MULHU=0x00000002, MULHSU=0xFFFFFFFF.

Source files
------------

// File: rtl/imul_pipe_pkg.sv
// Shared types and helpers for the pipelined integer multiplier.
// The mode enum is only consumed when IMUL_PIPE_MULH_EN is defined.
package imul_pipe_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } imul_mode_t;

  function automatic int BITS_PER_STAGE(input int nbits, input int nstages);
    return nbits / nstages;
  endfunction

endpackage

// File: rtl/imul_pipe_stage.sv
// One shift-add stage: folds BPS bits of b into the accumulator and
// registers {a_shifted, b_remaining, acc} when enabled.
module imul_pipe_stage
  import imul_pipe_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int BPS   = 8,
  parameter int AW    = NBITS
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [AW-1:0]    a_i,
  input  logic [NBITS-1:0] b_i,
  input  logic [AW-1:0]    acc_i,
  output logic [AW-1:0]    a_o,
  output logic [NBITS-1:0] b_o,
  output logic [AW-1:0]    acc_o
);

  logic [AW-1:0]    a_d, a_q;
  logic [NBITS-1:0] b_d, b_q;
  logic [AW-1:0]    acc_d, acc_q;

  always_comb begin
    acc_d = acc_i;
    for (int i = 0; i < BPS; i++) begin
      if (b_i[i]) begin
        acc_d = acc_d + (a_i << i);
      end
    end
    a_d = a_i << BPS;
    b_d = b_i >> BPS;
  end

  // Datapath only; validity lives in the top, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (en_i) begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/imul_pipe_param.sv
// Parametrised fixed-latency pipelined multiplier with val/rdy ports and global stall.
// Define IMUL_PIPE_MULH_EN to add recv_mode and the MULH/MULHSU/MULHU high-half results.
module imul_pipe_param
  import imul_pipe_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int NSTAGES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               recv_val,
  output logic               recv_rdy,
  input  logic [2*NBITS-1:0] recv_msg,
`ifdef IMUL_PIPE_MULH_EN
  input  logic [1:0]         recv_mode,
`endif
  output logic               send_val,
  input  logic               send_rdy,
  output logic [NBITS-1:0]   send_msg
);

  localparam int BPS = BITS_PER_STAGE(NBITS, NSTAGES);
`ifdef IMUL_PIPE_MULH_EN
  localparam int AW = 2 * NBITS;
`else
  localparam int AW = NBITS;
`endif

  logic [NSTAGES-1:0] val_d, val_q;
  logic               stall;
  logic [NBITS-1:0]   opA, opB;
  logic [AW-1:0]      aStage   [NSTAGES+1];
  logic [NBITS-1:0]   bStage   [NSTAGES+1];
  logic [AW-1:0]      accStage [NSTAGES+1];
  logic               unused_tail;

  assign stall    = val_q[NSTAGES-1] & ~send_rdy;
  assign recv_rdy = ~stall;
  assign send_val = val_q[NSTAGES-1];

  assign opA       = recv_msg[2*NBITS-1:NBITS];
  assign opB       = recv_msg[NBITS-1:0];
  assign bStage[0] = opB;

  always_comb begin
    val_d = val_q;
    if (!stall) begin
      val_d[0] = recv_val;
      for (int k = 1; k < NSTAGES; k++) begin
        val_d[k] = val_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

`ifdef IMUL_PIPE_MULH_EN
  imul_mode_t               inMode;
  logic                     aSigned, bSigned;
  logic [AW-1:0]            aHigh;
  logic [NSTAGES-1:0][1:0]  mode_q;

  assign inMode  = imul_mode_t'(recv_mode);
  assign aSigned = (inMode == MULH) || (inMode == MULHSU);
  assign bSigned = (inMode == MULH);
  assign aHigh   = {opA, {NBITS{1'b0}}};

  // Stages weight b's MSB as +2^(N-1); a signed b needs -2^(N-1), so seed acc with -a*2^N.
  assign aStage[0]   = {{NBITS{aSigned & opA[NBITS-1]}}, opA};
  assign accStage[0] = (bSigned & opB[NBITS-1]) ? (AW'(0) - aHigh) : '0;

  always_ff @(posedge clk) begin
    if (!stall) begin
      mode_q[0] <= recv_mode;
      for (int k = 1; k < NSTAGES; k++) begin
        mode_q[k] <= mode_q[k-1];
      end
    end
  end

  assign send_msg = (imul_mode_t'(mode_q[NSTAGES-1]) == MUL) ?
                    accStage[NSTAGES][NBITS-1:0] : accStage[NSTAGES][AW-1:NBITS];
`else
  assign aStage[0]   = opA;
  assign accStage[0] = '0;
  assign send_msg    = accStage[NSTAGES];
`endif

  for (genvar k = 0; k < NSTAGES; k++) begin : gStage
    imul_pipe_stage #(
      .NBITS (NBITS),
      .BPS   (BPS),
      .AW    (AW)
    ) uStage (
      .clk   (clk),
      .en_i  (~stall),
      .a_i   (aStage[k]),
      .b_i   (bStage[k]),
      .acc_i (accStage[k]),
      .a_o   (aStage[k+1]),
      .b_o   (bStage[k+1]),
      .acc_o (accStage[k+1])
    );
  end

  assign unused_tail = ^{aStage[NSTAGES], bStage[NSTAGES]};

`ifndef SYNTHESIS
  function automatic string line_trace();
    string recvStr, sendStr;
    recvStr = "-";
    sendStr = "-";
    if (recv_val & recv_rdy) recvStr = $sformatf("%h", recv_msg);
    if (send_val & send_rdy) sendStr = $sformatf("%h", send_msg);
    return $sformatf("%s |%b| %s", recvStr, val_q, sendStr);
  endfunction
`endif

endmodule

// File: tb/tb_imul_pipe_param.sv
// Self-checking bench for imul_pipe_param: queue-based reference model plus directed literals.
// Exercises the IMUL_PIPE_MULH_EN modes only when that macro is defined.
module tb_imul_pipe_param;

  localparam int NB = 32;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          recv_val = 1'b0;
  logic          recv_rdy;
  logic [63:0]   recv_msg = '0;
  logic [1:0]    recvMode = 2'd0;
  logic          send_val;
  logic          send_rdy = 1'b1;
  logic [31:0]   send_msg;

  logic          recvVal8 = 1'b0;
  logic          recvRdy8;
  logic [15:0]   recvMsg8 = '0;
  logic          sendVal8;
  logic [7:0]    sendMsg8;
  logic          run8 = 1'b0;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  logic [31:0]   qVal[$];
  int            qAge[$];
  logic [31:0]   outLog[$];
  int            outCyc[$];
  logic          expVal, expStall;
  logic [1:0]    effMode;

  logic          exp8Val [16];
  logic [7:0]    exp8Msg [16];
  int            idx8;

  always #5 clk = ~clk;

  imul_pipe_param #(.NBITS(NB), .NSTAGES(NS)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
`ifdef IMUL_PIPE_MULH_EN
    .recv_mode(recvMode),
`endif
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg)
  );

  imul_pipe_param #(.NBITS(8), .NSTAGES(8)) dut8 (
    .clk      (clk),
    .reset_n  (reset_n),
    .recv_val (recvVal8),
    .recv_rdy (recvRdy8),
    .recv_msg (recvMsg8),
`ifdef IMUL_PIPE_MULH_EN
    .recv_mode(2'b00),
`endif
    .send_val (sendVal8),
    .send_rdy (1'b1),
    .send_msg (sendMsg8)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    logic [63:0] ax, bx, p;
    ax = (m == 2'd1 || m == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    bx = (m == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ax * bx;
    return (m == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: each op ages once per unstalled edge and surfaces when its age reaches NS.
  always @(negedge clk) begin
`ifdef IMUL_PIPE_MULH_EN
    effMode = recvMode;
`else
    effMode = 2'd0;
`endif
    if (!reset_n) begin
      qVal.delete();
      qAge.delete();
      checkOutput("rst_send_val", 64'(send_val), 64'd0);
      checkOutput("rst_recv_rdy", 64'(recv_rdy), 64'd1);
    end else begin
      expVal   = (qAge.size() > 0) && (qAge[0] == NS);
      expStall = expVal && !send_rdy;
      checkOutput("send_val", 64'(send_val), 64'(expVal));
      checkOutput("recv_rdy", 64'(recv_rdy), 64'(!expStall));
      if (expVal) checkOutput("send_msg", 64'(send_msg), 64'(qVal[0]));
      if (send_val && send_rdy) begin
        outLog.push_back(send_msg);
        outCyc.push_back(cyc);
      end
      if (expVal && send_rdy) begin
        void'(qVal.pop_front());
        void'(qAge.pop_front());
      end
      if (!expStall) foreach (qAge[i]) qAge[i]++;
      if (recv_val && !expStall) begin
        qVal.push_back(golden(recv_msg[63:32], recv_msg[31:0], effMode));
        qAge.push_back(1);
      end
    end
  end

  // 8-bit, 8-stage instance with send_rdy tied high: fixed latency of 8 edges.
  always @(negedge clk) begin
    if (run8 && reset_n) begin
      idx8 = cyc % 16;
      checkOutput("sweep8_val", 64'(sendVal8), 64'(exp8Val[idx8]));
      checkOutput("sweep8_rdy", 64'(recvRdy8), 64'd1);
      if (exp8Val[idx8]) checkOutput("sweep8_msg", 64'(sendMsg8), 64'(exp8Msg[idx8]));
      exp8Val[idx8] = 1'b0;
      if (recvVal8) begin
        exp8Val[(cyc + 8) % 16] = 1'b1;
        exp8Msg[(cyc + 8) % 16] = 8'(recvMsg8[15:8] * recvMsg8[7:0]);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    logic took;
    int   waited;
    took   = 1'b0;
    waited = 0;
    recv_val = 1'b1;
    recv_msg = {a, b};
    recvMode = m;
    do begin
      @(negedge clk);
      took = recv_rdy;
      @(posedge clk);
      #1;
      waited++;
    end while (!took && waited < 50);
    checkOutput("accept", 64'(took), 64'd1);
  endtask

  task automatic idle();
    recv_val = 1'b0;
    recvMode = 2'd0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] b2bA [8] = '{32'hFFFFFFFF, 32'd7, 32'd0, 32'd1, 32'h00010000, 32'h1234, 32'hFFFFFFFF, 32'h0000ABCD};
    logic [31:0] b2bB [8] = '{32'd2, 32'hFFFFFFFD, 32'hDEADBEEF, 32'h80000000, 32'h00010000, 32'h5678, 32'hFFFFFFFF, 32'h100};
    logic [31:0] b2bE [8] = '{32'hFFFFFFFE, 32'hFFFFFFEB, 32'd0, 32'h80000000, 32'd0, 32'h06260060, 32'd1, 32'h00ABCD00};
    logic [31:0] bpE  [5] = '{32'd143, 32'd200, 32'd1, 32'd81, 32'd25};

    foreach (exp8Val[i]) begin
      exp8Val[i] = 1'b0;
      exp8Msg[i] = '0;
    end

    checkOutput("model_pin_neg", 64'(golden(32'd7, 32'hFFFFFFFD, 2'd0)), 64'hFFFFFFEB);
    checkOutput("model_pin_wrap", 64'(golden(32'hFFFFFFFF, 32'd2, 2'd0)), 64'hFFFFFFFE);

    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic 3*5");
    outLog.delete();
    applyStimulus(32'd3, 32'd5, 2'd0);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("basic_early_val", 64'(send_val), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("basic_val", 64'(send_val), 64'd1);
    checkOutput("basic_msg", 64'(send_msg), 64'd15);
    checkOutput("basic_rdy", 64'(recv_rdy), 64'd1);
    waitCycles(3);

    $display("[TB] back-to-back stream");
    outLog.delete();
    outCyc.delete();
    for (int i = 0; i < 8; i++) applyStimulus(b2bA[i], b2bB[i], 2'd0);
    idle();
    waitCycles(8);
    checkOutput("b2b_count", 64'(outLog.size()), 64'd8);
    for (int i = 0; i < 8 && i < outLog.size(); i++) begin
      checkOutput($sformatf("b2b_val%0d", i), 64'(outLog[i]), 64'(b2bE[i]));
      if (i > 0) checkOutput($sformatf("b2b_gap%0d", i), 64'(outCyc[i] - outCyc[i-1]), 64'd1);
    end

    $display("[TB] back-pressure");
    outLog.delete();
    send_rdy = 1'b0;
    applyStimulus(32'd11, 32'd13, 2'd0);
    applyStimulus(32'd2, 32'd100, 2'd0);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0);
    applyStimulus(32'd9, 32'd9, 2'd0);
    recv_msg = {32'd5, 32'd5};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_recv_rdy", 64'(recv_rdy), 64'd0);
      checkOutput("bp_send_val", 64'(send_val), 64'd1);
      checkOutput("bp_send_msg", 64'(send_msg), 64'd143);
      @(posedge clk);
      #1;
    end
    send_rdy = 1'b1;
    @(posedge clk);
    #1;
    idle();
    waitCycles(8);
    checkOutput("bp_count", 64'(outLog.size()), 64'd5);
    for (int i = 0; i < 5 && i < outLog.size(); i++)
      checkOutput($sformatf("bp_val%0d", i), 64'(outLog[i]), 64'(bpE[i]));

    $display("[TB] reset mid-flight");
    outLog.delete();
    applyStimulus(32'd2, 32'd3, 2'd0);
    applyStimulus(32'd4, 32'd5, 2'd0);
    applyStimulus(32'd6, 32'd7, 2'd0);
    idle();
    @(posedge clk);
    #2;
    checkOutput("prereset_val", 64'(send_val), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("reset_send_val", 64'(send_val), 64'd0);
    checkOutput("reset_recv_rdy", 64'(recv_rdy), 64'd1);
    @(posedge clk);
    #2 reset_n = 1'b1;
    waitCycles(8);
    checkOutput("no_stale", 64'(outLog.size()), 64'd0);
    applyStimulus(32'd6, 32'd7, 2'd0);
    idle();
    waitCycles(6);
    checkOutput("post_reset_count", 64'(outLog.size()), 64'd1);
    if (outLog.size() > 0) checkOutput("post_reset_msg", 64'(outLog[0]), 64'd42);

`ifdef IMUL_PIPE_MULH_EN
    $display("[TB] high-half modes");
    outLog.delete();
    for (int m = 0; m < 4; m++) applyStimulus(32'hFFFFFFFE, 32'd3, 2'(m));
    idle();
    waitCycles(6);
    checkOutput("mulh_count", 64'(outLog.size()), 64'd4);
    if (outLog.size() == 4) begin
      checkOutput("mode_mul", 64'(outLog[0]), 64'hFFFFFFFA);
      checkOutput("mode_mulh", 64'(outLog[1]), 64'hFFFFFFFF);
      checkOutput("mode_mulhsu", 64'(outLog[2]), 64'hFFFFFFFF);
      checkOutput("mode_mulhu", 64'(outLog[3]), 64'h00000002);
    end
`endif

    $display("[TB] random traffic with back-pressure");
    for (int i = 0; i < 300; i++) begin
      recv_val = 1'($urandom_range(0, 1));
      recv_msg = {32'($urandom), 32'($urandom)};
`ifdef IMUL_PIPE_MULH_EN
      recvMode = 2'($urandom_range(0, 3));
`endif
      send_rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    idle();
    send_rdy = 1'b1;
    waitCycles(10);
    checkOutput("drain_empty", 64'(qVal.size()), 64'd0);

    $display("[TB] 8-bit x 8-stage sweep");
    run8 = 1'b1;
    for (int i = 0; i < 150; i++) begin
      recvVal8 = 1'($urandom_range(0, 1));
      recvMsg8 = 16'($urandom);
      @(posedge clk);
      #1;
    end
    recvVal8 = 1'b0;
    waitCycles(10);
    run8 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
